// File: rtl/wave_addr_sequencer.sv
// Phase-accumulator address sequencer for three shared-address waveform ROMs.
// Frequency and waveform changes take effect only at period boundaries.
module wave_addr_sequencer #(
  parameter int ACC_W   = 32,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ACC_W-1:0]  freq_word,
  input  logic              freq_load,
  input  logic [1:0]        wave_sel,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rom_sin,
  input  logic [DATA_W-1:0] rom_sq,
  input  logic [DATA_W-1:0] rom_tri,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              period_tick
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt, sum;
  logic               carry, wrap;
  logic [ACC_W-1:0]   freq_pend, freq_act, freq_act_nxt, freq_eff;
  logic [1:0]         sel_act, sel_nxt;
  logic [ROM_LAT-1:0] vld_sh;
  logic [1:0]         sel_sh [ROM_LAT];
  logic [DATA_W-1:0]  mux_val;

  // A load arriving on the wrap edge itself must still apply to that wrap.
  always_comb begin
    {carry, sum} = {1'b0, acc} + {1'b0, freq_act};
    freq_eff     = freq_load ? freq_word : freq_pend;
    wrap         = (state != IDLE) && carry;
    state_nxt    = state;
    acc_nxt      = acc;
    freq_act_nxt = freq_act;
    sel_nxt      = sel_act;
    case (state)
      IDLE: begin
        acc_nxt      = '0;
        freq_act_nxt = freq_eff;
        if (en) begin
          state_nxt = RUN;
          sel_nxt   = wave_sel;
        end
      end
      RUN: begin
        acc_nxt = sum;
        if (!en) state_nxt = STOP;
      end
      STOP: begin
        acc_nxt = sum;
        if (wrap) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
        end else if (en) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (wrap) begin
      freq_act_nxt = freq_eff;
      sel_nxt      = wave_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      freq_pend   <= '0;
      freq_act    <= '0;
      sel_act     <= '0;
      period_tick <= 1'b0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      freq_act    <= freq_act_nxt;
      sel_act     <= sel_nxt;
      period_tick <= wrap;
      if (freq_load) freq_pend <= freq_word;
    end
  end

  assign addr = acc[ACC_W-1 -: ADDR_W];
  assign busy = (state != IDLE);

  // Issue flag and select travel alongside the ROM read so the mux sees the
  // select that was active when the address was presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sh <= '0;
      for (int i = 0; i < ROM_LAT; i++) sel_sh[i] <= 2'd0;
    end else begin
      vld_sh[0] <= busy;
      sel_sh[0] <= sel_act;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_sh[i] <= vld_sh[i-1];
        sel_sh[i] <= sel_sh[i-1];
      end
    end
  end

  always_comb begin
    mux_val = {1'b1, {(DATA_W-1){1'b0}}};
    case (sel_sh[ROM_LAT-1])
      2'd0:    mux_val = rom_sin;
      2'd1:    mux_val = rom_sq;
      2'd2:    mux_val = rom_tri;
      default: mux_val = {1'b1, {(DATA_W-1){1'b0}}};
    endcase
  end

  // dout is only updated by valid samples so it holds once the run ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= vld_sh[ROM_LAT-1];
      if (vld_sh[ROM_LAT-1]) dout <= mux_val;
    end
  end

endmodule

// File: tb/tb_wave_addr_sequencer.sv
// Directed bench for wave_addr_sequencer with a one-cycle-latency ROM model.
// ROM contents: sin = ~a[11:4], sq = a[11:4]^8'hA5, tri = a[11:4]+8'h11.
module tb_wave_addr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] freq_word = '0;
  logic        freq_load = 1'b0;
  logic [1:0]  wave_sel = 2'd0;
  logic [11:0] addr;
  logic [7:0]  rom_sin = '0, rom_sq = '0, rom_tri = '0;
  logic [7:0]  dout;
  logic        dout_valid, busy, period_tick;

  int total = 0;
  int bad = 0;

  wave_addr_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .freq_word(freq_word), .freq_load(freq_load),
    .wave_sel(wave_sel), .addr(addr), .rom_sin(rom_sin), .rom_sq(rom_sq),
    .rom_tri(rom_tri), .dout(dout), .dout_valid(dout_valid), .busy(busy),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_sin <= ~addr[11:4];
    rom_sq  <= addr[11:4] ^ 8'hA5;
    rom_tri <= addr[11:4] + 8'h11;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset for one edge, then load freq and request run together (edge E0).
  task automatic start(input logic [31:0] f, input logic [1:0] s);
    rst = 1'b1; en = 1'b0; freq_load = 1'b0;
    tick(1);
    rst = 1'b0; freq_word = f; freq_load = 1'b1; wave_sel = s; en = 1'b1;
    tick(1);
    freq_load = 1'b0;
  endtask

  int ticks;
  int addr_moves;

  initial begin
    tick(2);
    check("rst_addr", addr, 0);
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_tick", period_tick, 0);

    // Triangle at step 0x100: 16-cycle period, two-edge output latency.
    start(32'h1000_0000, 2'd2);
    check("t1_busy", busy, 1);
    check("t1_addr0", addr, 12'h000);
    tick(1);
    check("t1_addr1", addr, 12'h100);
    check("t1_valid_e1", dout_valid, 0);
    tick(1);
    check("t1_valid_e2", dout_valid, 1);
    check("t1_dout_e2", dout, 8'h11);
    check("t1_addr2", addr, 12'h200);
    tick(1);
    check("t1_dout_e3", dout, 8'h21);
    tick(12);
    check("t1_addr15", addr, 12'hF00);
    check("t1_tick15", period_tick, 0);
    tick(1);
    check("t1_addr16", addr, 12'h000);
    check("t1_tick16", period_tick, 1);
    tick(1);
    check("t1_addr17", addr, 12'h100);
    check("t1_tick17", period_tick, 0);
    check("t1_dout17", dout, 8'h01);

    // Mid-period frequency load waits for the wrap.
    freq_word = 32'h2000_0000; freq_load = 1'b1;
    tick(1);
    freq_load = 1'b0;
    check("fl_addr18", addr, 12'h200);
    tick(1);
    check("fl_addr19", addr, 12'h300);
    tick(12);
    check("fl_addr31", addr, 12'hF00);
    tick(1);
    check("fl_addr32", addr, 12'h000);
    check("fl_tick32", period_tick, 1);
    tick(1);
    check("fl_addr33", addr, 12'h200);
    tick(1);
    check("fl_addr34", addr, 12'h400);

    // Load coinciding with the wrap edge applies to that wrap.
    start(32'h1000_0000, 2'd2);
    tick(15);
    check("wl_addr15", addr, 12'hF00);
    freq_word = 32'h3000_0000; freq_load = 1'b1;
    tick(1);
    freq_load = 1'b0;
    check("wl_addr16", addr, 12'h000);
    tick(1);
    check("wl_addr17", addr, 12'h300);

    // Drop en mid-period: finish the period, then idle.
    start(32'h1000_0000, 2'd2);
    tick(3);
    check("st_addr3", addr, 12'h300);
    en = 1'b0;
    tick(1);
    check("st_busy4", busy, 1);
    check("st_addr4", addr, 12'h400);
    tick(11);
    check("st_busy15", busy, 1);
    check("st_addr15", addr, 12'hF00);
    tick(1);
    check("st_busy16", busy, 0);
    check("st_addr16", addr, 12'h000);
    check("st_tick16", period_tick, 1);
    tick(1);
    check("st_valid17", dout_valid, 1);
    check("st_dout17", dout, 8'h01);
    tick(1);
    check("st_valid18", dout_valid, 0);
    check("st_hold18", dout, 8'h01);
    tick(2);
    check("st_busy20", busy, 0);
    check("st_addr20", addr, 12'h000);

    // Reset mid-run flushes everything in flight.
    start(32'h1000_0000, 2'd2);
    tick(5);
    check("rr_addr5", addr, 12'h500);
    check("rr_valid5", dout_valid, 1);
    rst = 1'b1; en = 1'b0;
    tick(1);
    rst = 1'b0;
    check("rr_addr", addr, 0);
    check("rr_dout", dout, 0);
    check("rr_valid", dout_valid, 0);
    check("rr_busy", busy, 0);
    check("rr_tick", period_tick, 0);
    tick(1);
    check("rr_valid7", dout_valid, 0);
    tick(1);
    check("rr_valid8", dout_valid, 0);

    // Midscale select with zero step: constant addr, no ticks.
    start(32'h0, 2'd3);
    tick(2);
    check("ms_valid", dout_valid, 1);
    check("ms_dout", dout, 8'h80);
    ticks = 0; addr_moves = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (period_tick) ticks++;
      if (addr != 12'h000) addr_moves++;
    end
    check("ms_ticks", ticks, 0);
    check("ms_addr_moves", addr_moves, 0);
    check("ms_valid_end", dout_valid, 1);

    // Select change at 0x7F0 only takes effect from the wrap.
    start(32'h0010_0000, 2'd0);
    tick(2032);
    check("ws_addr7f0", addr, 12'h7F0);
    wave_sel = 2'd1;
    tick(1);
    check("ws_dout2033", dout, 8'h81);
    tick(1);
    check("ws_dout2034", dout, 8'h80);
    tick(2062);
    check("ws_addr4096", addr, 12'h000);
    check("ws_tick4096", period_tick, 1);
    tick(1);
    check("ws_dout4097", dout, 8'h00);
    tick(1);
    check("ws_dout4098", dout, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
